vga_scan_pipeline: RTL and testbench

Parametrised VGA scan-out engine. It generates raster timing, issues framebuffer read coordinates, and maps returned color codes through a writable palette. It drives latency-matched, blanked RGB plus sync to the video DAC. It sits between the pixel clock domain (PLL output) and the pixel store, replacing the fixed-timing controller / decode / blank chain. It adds test-pattern modes, pixel scaling, and configurable memory latency.

---
 rtl/vga_scan_pipeline.sv | 154 +++++++++++++++
 tb/tb_vga_scan_pipeline.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_pipeline.sv
// rtl/vga_scan_pipeline.sv - VGA raster timing, framebuffer fetch, palette lookup and blanked RGB/sync output.
module vga_scan_pipeline #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int COLOR_BITS  = 4,
   parameter int CODE_BITS   = 3,
   parameter int MEM_LAT     = 1,
   parameter int SCALE_SHIFT = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              mode,
   input  logic [CODE_BITS-1:0]    solid_code,
   output logic [9:0]              rd_x,
   output logic [9:0]              rd_y,
   input  logic [CODE_BITS-1:0]    rd_code,
   input  logic                    pal_we,
   input  logic [CODE_BITS-1:0]    pal_addr,
   input  logic [3*COLOR_BITS-1:0] pal_data,
   output logic                    hsync,
   output logic                    vsync,
   output logic [COLOR_BITS-1:0]   r,
   output logic [COLOR_BITS-1:0]   g,
   output logic [COLOR_BITS-1:0]   b,
   output logic                    frame_start
);
   localparam int CW      = 12;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int LAT     = MEM_LAT + 1;
   localparam int PAL_N   = 1 << CODE_BITS;
   localparam int RGB_W   = 3 * COLOR_BITS;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] BAR_W  = CW'(H_ACTIVE / 8);

   function automatic logic [RGB_W-1:0] pal_default(input int idx);
      logic [2:0] c;
      c = 3'(idx);
      return {{COLOR_BITS{c[2]}}, {COLOR_BITS{c[1]}}, {COLOR_BITS{c[0]}}};
   endfunction

   logic [CW-1:0]        hcnt, vcnt;
   logic                 frame_top;
   logic [1:0]           mode_q, mode_eff;
   logic [CODE_BITS-1:0] solid_q, solid_eff, pat_code;
   logic                 active0, hs0_n, vs0_n;

   // flag word: {frame_start, vs_n, hs_n, active}
   logic [3:0]           flag_pipe [LAT];
   logic [CODE_BITS-1:0] pat_pipe  [MEM_LAT];
   logic                 fb_pipe   [MEM_LAT];
   logic [RGB_W-1:0]     pal       [PAL_N];
   logic [RGB_W-1:0]     rgb_q;
   logic [CODE_BITS-1:0] ret_code;
   logic                 ret_active;

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

   assign rd_x = 10'(hcnt >> SCALE_SHIFT);
   assign rd_y = 10'(vcnt >> SCALE_SHIFT);

   // The frame's first pixel uses the live inputs; the latch then holds them for the frame.
   assign frame_top = (hcnt == '0) && (vcnt == '0);
   assign mode_eff  = frame_top ? mode : mode_q;
   assign solid_eff = frame_top ? solid_code : solid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q  <= 2'b00;
         solid_q <= '0;
      end else if (frame_top) begin
         mode_q  <= mode;
         solid_q <= solid_code;
      end
   end

   assign active0 = (hcnt < H_ACT) && (vcnt < V_ACT);
   assign hs0_n   = !((hcnt >= HS_BEG) && (hcnt < HS_END));
   assign vs0_n   = !((vcnt >= VS_BEG) && (vcnt < VS_END));

   always_comb begin
      pat_code = '0;
      case (mode_eff)
         2'b01:   pat_code = solid_eff;
         2'b10:   pat_code = CODE_BITS'(hcnt / BAR_W);
         2'b11:   pat_code = (hcnt[5] ^ vcnt[5]) ? solid_eff : '0;
         default: pat_code = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) flag_pipe[i] <= 4'b0110;
         for (int i = 0; i < MEM_LAT; i++) begin
            pat_pipe[i] <= '0;
            fb_pipe[i]  <= 1'b0;
         end
      end else begin
         flag_pipe[0] <= {frame_top, vs0_n, hs0_n, active0};
         for (int i = 1; i < LAT; i++) flag_pipe[i] <= flag_pipe[i-1];
         pat_pipe[0] <= pat_code;
         fb_pipe[0]  <= (mode_eff == 2'b00);
         for (int i = 1; i < MEM_LAT; i++) begin
            pat_pipe[i] <= pat_pipe[i-1];
            fb_pipe[i]  <= fb_pipe[i-1];
         end
      end
   end

   assign ret_code   = fb_pipe[MEM_LAT-1] ? rd_code : pat_pipe[MEM_LAT-1];
   assign ret_active = flag_pipe[MEM_LAT-1][0];

   // Read and write share an edge, so a same-cycle write is seen one clock later.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PAL_N; i++) pal[i] <= pal_default(i);
         rgb_q <= '0;
      end else begin
         if (pal_we) pal[pal_addr] <= pal_data;
         rgb_q <= ret_active ? pal[ret_code] : '0;
      end
   end

   assign r           = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
   assign g           = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
   assign b           = rgb_q[COLOR_BITS-1:0];
   assign hsync       = flag_pipe[LAT-1][1];
   assign vsync       = flag_pipe[LAT-1][2];
   assign frame_start = flag_pipe[LAT-1][3];
endmodule

// File: tb/tb_vga_scan_pipeline.sv
// tb/tb_vga_scan_pipeline.sv - randomized bench with a raster/palette reference model for vga_scan_pipeline.
module tb_vga_scan_pipeline;
   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 40, VF = 2, VS = 2, VB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int ML = 3, SS = 1, L = ML + 1;
   localparam int MAXC = 6 * FRAME;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mode;
   logic [2:0]  solid_code, rd_code, pal_addr;
   logic [9:0]  rd_x, rd_y;
   logic        pal_we;
   logic [11:0] pal_data;
   logic        hsync, vsync, frame_start;
   logic [3:0]  r, g, b;

   always #5 clk = ~clk;

   vga_scan_pipeline #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .COLOR_BITS(4), .CODE_BITS(3), .MEM_LAT(ML), .SCALE_SHIFT(SS)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .solid_code(solid_code),
      .rd_x(rd_x), .rd_y(rd_y), .rd_code(rd_code),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b), .frame_start(frame_start)
   );

   int errors = 0, checks = 0;
   int e = 0, run = 0;
   bit started = 0;
   int hs_low = 0, vs_low = 0, fs_cnt = 0, rx_max = 0, ry_max = 0;
   logic [2:0]  fbm [64][64];
   logic [11:0] pal_m [8];
   logic [1:0]  mode_log [MAXC];
   logic [2:0]  solid_log [MAXC];
   logic [9:0]  ax_q [ML];
   logic [9:0]  ay_q [ML];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s run=%0d e=%0d actual=%h required=%h", name, run, e, act, exp);
      end
   endtask

   task automatic reset_pal();
      for (int i = 0; i < 8; i++) begin
         logic [2:0] c;
         c = 3'(i);
         pal_m[i] = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
      end
   endtask

   // Expected {frame_start, vsync, hsync, rgb} for the raster position at stage cycle s.
   function automatic logic [14:0] exp_out(input int s);
      int h, v, f;
      logic act, hs_n, vs_n;
      logic [2:0] code;
      if (s < 0) return {1'b0, 1'b1, 1'b1, 12'h000};
      h = s % HT;
      v = (s / HT) % VT;
      f = s - (s % FRAME);
      act  = (h < HA) && (v < VA);
      hs_n = !((h >= HA + HF) && (h < HA + HF + HS));
      vs_n = !((v >= VA + VF) && (v < VA + VF + VS));
      case (mode_log[f])
         2'd0: code = fbm[v >> SS][h >> SS];
         2'd1: code = solid_log[f];
         2'd2: code = 3'(h / (HA / 8));
         default: code = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? solid_log[f] : 3'd0;
      endcase
      return {(s % FRAME) == 0, vs_n, hs_n, act ? pal_m[code] : 12'h000};
   endfunction

   task automatic tick(input logic rst, input logic [1:0] md, input logic [2:0] sc,
                       input logic we, input logic [2:0] wa, input logic [11:0] wd);
      reset = rst; mode = md; solid_code = sc;
      pal_we = we; pal_addr = wa; pal_data = wd;
      rd_code = fbm[ay_q[ML-1][5:0]][ax_q[ML-1][5:0]];
      if (started) begin
         chk("rd_xy", {12'd0, rd_x, rd_y}, {12'd0, 10'((e % HT) >> SS), 10'(((e / HT) % VT) >> SS)});
         if (!rst && e < MAXC) begin
            mode_log[e] = md;
            solid_log[e] = sc;
         end
      end
      for (int i = ML - 1; i > 0; i--) begin
         ax_q[i] = ax_q[i-1];
         ay_q[i] = ay_q[i-1];
      end
      ax_q[0] = rd_x;
      ay_q[0] = rd_y;
      @(posedge clk);
      #1;
      if (rst) begin
         e = 0;
         started = 1;
         reset_pal();
      end else begin
         e++;
      end
      chk("out", {17'd0, frame_start, vsync, hsync, r, g, b}, {17'd0, exp_out(e - L)});
      if (rst) chk("rst_blank", {16'd0, hsync, vsync, r, g, b}, {16'd0, 1'b1, 1'b1, 12'h000});
      if (!rst && we) pal_m[wa] = wd;
   endtask

   initial begin
      for (int y = 0; y < 64; y++)
         for (int x = 0; x < 64; x++) fbm[y][x] = 3'($urandom);
      for (int i = 0; i < ML; i++) begin
         ax_q[i] = '0;
         ay_q[i] = '0;
      end
      reset_pal();
      repeat (3) tick(1'b1, 2'd0, 3'd0, 1'b0, 3'd0, 12'h0);
      run = 1;
      for (int it = 0; it < 40000; it++) begin
         int f, line, col;
         logic rst, we;
         logic [1:0] md;
         logic [2:0] sc, wa;
         logic [11:0] wd;
         f = e / FRAME;
         line = (e % FRAME) / HT;
         col = e % HT;
         rst = 1'b0;
         md = 2'($urandom);
         sc = 3'($urandom);
         we = 1'b0;
         wa = 3'($urandom);
         wd = 12'($urandom);
         if (run == 1) begin
            case (f)
               0: md = (line < 10) ? 2'd0 : 2'd2;
               1: md = 2'd2;
               2: md = 2'd1;
               3: md = (line < 5) ? 2'd3 : 2'($urandom);
               4: begin
                  md = 2'd1;
                  sc = 3'd2;
                  if (e == 4 * FRAME + 10 + ML) begin
                     we = 1'b1; wa = 3'd2; wd = 12'h123;
                  end
               end
               default: begin
                  we = ($urandom_range(7) == 0);
                  if (e == 5 * FRAME + 20 * HT + 30) rst = 1'b1;
               end
            endcase
            if (e < 2 * FRAME && col < HA && line < VA) begin
               if (rd_x > rx_max) rx_max = rd_x;
               if (rd_y > ry_max) ry_max = rd_y;
            end
         end else begin
            we = ($urandom_range(5) == 0);
         end
         tick(rst, md, sc, we, wa, wd);
         if (rst) begin
            run = 2;
            continue;
         end
         if (run == 1) begin
            if (e >= L && e < L + 2 * FRAME) begin
               if (!hsync) hs_low++;
               if (!vsync) vs_low++;
               if (frame_start) fs_cnt++;
            end
            if (e == FRAME + 3 + L)  chk("bar0", {20'd0, r, g, b}, 32'h000);
            if (e == FRAME + 40 + L) chk("bar5", {20'd0, r, g, b}, 32'hF0F);
            if (e == FRAME + 47 + L) chk("bar5_edge", {20'd0, r, g, b}, 32'hF0F);
            if (e == FRAME + 48 + L) chk("bar6", {20'd0, r, g, b}, 32'hFF0);
            if (e == FRAME + 60 + L) chk("bar7", {20'd0, r, g, b}, 32'hFFF);
            if (e == 4 * FRAME + ML + 11) chk("pal_old", {20'd0, r, g, b}, 32'h0F0);
            if (e == 4 * FRAME + ML + 12) chk("pal_new", {20'd0, r, g, b}, 32'h123);
            if (e == L + 2 * FRAME) begin
               chk("hs_low_cnt", hs_low, 2 * HS * VT);
               chk("vs_low_cnt", vs_low, 2 * VS * HT);
               chk("fs_cnt", fs_cnt, 2);
               chk("rd_x_max", rx_max, 31);
               chk("rd_y_max", ry_max, 19);
            end
         end else begin
            if (e == L - 1) chk("fs_early", {31'd0, frame_start}, 32'd0);
            if (e == L)     chk("fs_first", {31'd0, frame_start}, 32'd1);
            if (e >= 2 * FRAME + L + 8) break;
         end
      end
      if (run != 2) chk("script_end", run, 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
